// File: rtl/time_keeper.sv
// time_keeper: BCD hh:mm:ss wall clock with button-driven set mode and field blinking.
// Optional alarm compare is compiled in when ALARM_EN is defined.
module time_keeper #(
    parameter int HOURS = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       tick_blink,
    input  logic       btn_mode,
    input  logic       btn_inc,
`ifdef ALARM_EN
    input  logic [7:0] alarm_hr_bcd,
    input  logic [7:0] alarm_min_bcd,
    output logic       alarm,
`endif
    output logic [7:0] hr_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [2:0] blank,
    output logic       day_tick,
    output logic       set_mode
);

    typedef enum logic [1:0] {RUN, SET_HR, SET_MIN} state_t;

    localparam logic [7:0] HR_RST = (HOURS == 12) ? 8'h12 : 8'h00;
    localparam logic [7:0] HR_TOP = (HOURS == 12) ? 8'h12 : 8'h23;
    localparam logic [7:0] HR_BOT = (HOURS == 12) ? 8'h01 : 8'h00;

    state_t state;
    state_t state_nx;

    logic consume;
    logic mode_ev;
    logic inc_ev;
    logic run_tick;
    logic sec_wrap;
    logic min_wrap;
    logic day_wrap;

    function automatic logic [7:0] inc_digits(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            inc_digits = {v[7:4] + 4'd1, 4'd0};
        else
            inc_digits = {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_60(input logic [7:0] v);
        inc_60 = (v == 8'h59) ? 8'h00 : inc_digits(v);
    endfunction

    function automatic logic [7:0] inc_hr(input logic [7:0] v);
        inc_hr = (v == HR_TOP) ? HR_BOT : inc_digits(v);
    endfunction

`ifdef ALARM_EN
    // A button press while the alarm rings only silences it.
    assign consume = alarm & (btn_mode | btn_inc);
`else
    assign consume = 1'b0;
`endif

    assign mode_ev  = btn_mode & ~consume;
    assign inc_ev   = btn_inc & ~btn_mode & ~consume;
    assign run_tick = (state == RUN) & tick;
    assign sec_wrap = (sec_bcd == 8'h59);
    assign min_wrap = (min_bcd == 8'h59);
    assign day_wrap = run_tick & sec_wrap & min_wrap & (hr_bcd == HR_TOP);

    always_comb begin
        state_nx = state;
        unique case (state)
            RUN:     if (mode_ev) state_nx = SET_HR;
            SET_HR:  if (mode_ev) state_nx = SET_MIN;
            SET_MIN: if (mode_ev) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            hr_bcd   <= HR_RST;
            min_bcd  <= 8'h00;
            sec_bcd  <= 8'h00;
            blank    <= 3'b000;
            day_tick <= 1'b0;
            set_mode <= 1'b0;
        end else begin
            state    <= state_nx;
            set_mode <= (state_nx != RUN);
            day_tick <= day_wrap;
            unique case (state_nx)
                SET_HR:  blank <= {tick_blink, 2'b00};
                SET_MIN: blank <= {1'b0, tick_blink, 1'b0};
                default: blank <= 3'b000;
            endcase
            if (run_tick) begin
                sec_bcd <= inc_60(sec_bcd);
                if (sec_wrap) begin
                    min_bcd <= inc_60(min_bcd);
                    if (min_wrap)
                        hr_bcd <= inc_hr(hr_bcd);
                end
            end
            if (state == SET_HR && inc_ev)
                hr_bcd <= inc_hr(hr_bcd);
            if (state == SET_MIN && inc_ev)
                min_bcd <= inc_60(min_bcd);
            if (state == SET_MIN && mode_ev)
                sec_bcd <= 8'h00;
        end
    end

`ifdef ALARM_EN
    logic fresh;
    logic match;

    // Compare only right after a running tick so a silenced alarm stays silent.
    assign match = (state == RUN) & fresh & (sec_bcd == 8'h00)
                 & (hr_bcd == alarm_hr_bcd) & (min_bcd == alarm_min_bcd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fresh <= 1'b0;
            alarm <= 1'b0;
        end else begin
            fresh <= run_tick;
            if (match)
                alarm <= 1'b1;
            else if (consume || (run_tick && sec_wrap))
                alarm <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed test of a 24 h and a 12 h time_keeper against a behavioural model.
// Alarm checks are included when ALARM_EN is defined.
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_v  [2];
    logic       blink_v [2];
    logic       bm_v    [2];
    logic       bi_v    [2];
    logic [7:0] hr_o    [2];
    logic [7:0] min_o   [2];
    logic [7:0] sec_o   [2];
    logic [2:0] blank_o [2];
    logic       dt_o    [2];
    logic       sm_o    [2];
`ifdef ALARM_EN
    logic [7:0] ahr_v   [2];
    logic [7:0] amin_v  [2];
    logic       al_o    [2];
`endif

    int n_chk  = 0;
    int n_fail = 0;
    bit run_chk = 0;

    always #5 clk = ~clk;

    time_keeper #(.HOURS(24)) dut24 (
        .clk(clk), .rst_n(rst_n),
        .tick(tick_v[0]), .tick_blink(blink_v[0]),
        .btn_mode(bm_v[0]), .btn_inc(bi_v[0]),
`ifdef ALARM_EN
        .alarm_hr_bcd(ahr_v[0]), .alarm_min_bcd(amin_v[0]), .alarm(al_o[0]),
`endif
        .hr_bcd(hr_o[0]), .min_bcd(min_o[0]), .sec_bcd(sec_o[0]),
        .blank(blank_o[0]), .day_tick(dt_o[0]), .set_mode(sm_o[0])
    );

    time_keeper #(.HOURS(12)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .tick(tick_v[1]), .tick_blink(blink_v[1]),
        .btn_mode(bm_v[1]), .btn_inc(bi_v[1]),
`ifdef ALARM_EN
        .alarm_hr_bcd(ahr_v[1]), .alarm_min_bcd(amin_v[1]), .alarm(al_o[1]),
`endif
        .hr_bcd(hr_o[1]), .min_bcd(min_o[1]), .sec_bcd(sec_o[1]),
        .blank(blank_o[1]), .day_tick(dt_o[1]), .set_mode(sm_o[1])
    );

    // Model: time as plain integers, mode 0=run 1=set hours 2=set minutes
    int       mh [2];
    int       mm [2];
    int       ms [2];
    int       mst[2];
    bit       mdt[2];
    bit [2:0] mbl[2];
    bit       mal[2];
    bit       mpend[2];

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic int nexth(input int h, input int hrs);
        return (hrs == 24) ? (h + 1) % 24 : (h % 12) + 1;
    endfunction

    task automatic model_reset(input int i);
        mh[i] = (i == 1) ? 12 : 0;
        mm[i] = 0; ms[i] = 0; mst[i] = 0;
        mdt[i] = 0; mbl[i] = 0; mal[i] = 0; mpend[i] = 0;
    endtask

    task automatic model_step(input int i);
        int  hrs;
        bit  cons;
        bit  rt;
        hrs  = (i == 1) ? 12 : 24;
        cons = 0;
`ifdef ALARM_EN
        cons = mal[i] && (bm_v[i] || bi_v[i]);
`endif
        rt = (mst[i] == 0) && tick_v[i];
        mdt[i] = 0;
`ifdef ALARM_EN
        if (mpend[i] && mst[i] == 0 && ms[i] == 0
            && bcd(mh[i]) == ahr_v[i] && bcd(mm[i]) == amin_v[i])
            mal[i] = 1;
        else if (cons || (rt && ms[i] == 59))
            mal[i] = 0;
        mpend[i] = rt;
`endif
        case (mst[i])
            0: begin
                if (rt) begin
                    if (ms[i] == 59) begin
                        ms[i] = 0;
                        if (mm[i] == 59) begin
                            mm[i] = 0;
                            if (mh[i] == ((hrs == 24) ? 23 : 12)) mdt[i] = 1;
                            mh[i] = nexth(mh[i], hrs);
                        end else mm[i] = mm[i] + 1;
                    end else ms[i] = ms[i] + 1;
                end
                if (bm_v[i] && !cons) mst[i] = 1;
            end
            1: begin
                if (bm_v[i]) mst[i] = 2;
                else if (bi_v[i]) mh[i] = nexth(mh[i], hrs);
            end
            default: begin
                if (bm_v[i]) begin mst[i] = 0; ms[i] = 0; end
                else if (bi_v[i]) mm[i] = (mm[i] + 1) % 60;
            end
        endcase
        mbl[i] = (mst[i] == 1) ? {blink_v[i], 2'b00} :
                 (mst[i] == 2) ? {1'b0, blink_v[i], 1'b0} : 3'b000;
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) model_reset(i);
            else model_step(i);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_chk) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("hr%0d", i), 32'(hr_o[i]), 32'(bcd(mh[i])));
                chk($sformatf("min%0d", i), 32'(min_o[i]), 32'(bcd(mm[i])));
                chk($sformatf("sec%0d", i), 32'(sec_o[i]), 32'(bcd(ms[i])));
                chk($sformatf("blank%0d", i), 32'(blank_o[i]), 32'(mbl[i]));
                chk($sformatf("day_tick%0d", i), 32'(dt_o[i]), 32'(mdt[i]));
                chk($sformatf("set_mode%0d", i), 32'(sm_o[i]), 32'(mst[i] != 0));
`ifdef ALARM_EN
                chk($sformatf("alarm%0d", i), 32'(al_o[i]), 32'(mal[i]));
`endif
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int i, input bit t, input bit m, input bit b);
        tick_v[i] = t; bm_v[i] = m; bi_v[i] = b;
        @(negedge clk);
        tick_v[i] = 0; bm_v[i] = 0; bi_v[i] = 0;
    endtask

    task automatic pulses(input int i, input int n, input bit t, input bit b);
        for (int k = 0; k < n; k++) pulse(i, t, 1'b0, b);
    endtask

    initial begin
        rst_n = 0;
        for (int i = 0; i < 2; i++) begin
            tick_v[i] = 0; blink_v[i] = 0; bm_v[i] = 0; bi_v[i] = 0;
        end
`ifdef ALARM_EN
        ahr_v[0] = 8'h99; amin_v[0] = 8'h99;
        ahr_v[1] = 8'h01; amin_v[1] = 8'h00;
`endif
        @(posedge clk);
        run_chk = 1;
        cyc(2);
        rst_n = 1;
        cyc(1);

        // reset state and first ticks
        chk("rst_hr24", 32'(hr_o[0]), 32'h00);
        chk("rst_hr12", 32'(hr_o[1]), 32'h12);
        chk("rst_blank", 32'(blank_o[0]), 32'h0);
        pulses(0, 3, 1'b1, 1'b0);
        chk("sec_3ticks", 32'(sec_o[0]), 32'h03);

        // preload 23:59 then 59 ticks
        pulse(0, 0, 1, 0);
        pulses(0, 23, 1'b0, 1'b1);
        chk("set_hr23", 32'(hr_o[0]), 32'h23);
        pulse(0, 0, 1, 0);
        pulses(0, 59, 1'b0, 1'b1);
        pulse(0, 0, 1, 0);
        chk("exit_sec_clr", 32'(sec_o[0]), 32'h00);
        pulses(0, 59, 1'b1, 1'b0);
        chk("pre_roll", 32'({hr_o[0], min_o[0], sec_o[0]}), 32'h235959);
        pulse(0, 1, 0, 0);
        chk("roll_time", 32'({hr_o[0], min_o[0], sec_o[0]}), 32'h000000);
        chk("roll_dt", 32'(dt_o[0]), 32'h1);
        cyc(1);
        chk("roll_dt_off", 32'(dt_o[0]), 32'h0);

        // set hours, blink, frozen seconds
        pulses(0, 7, 1'b1, 1'b0);
        pulse(0, 0, 0, 1);
        chk("run_inc_ign", 32'({hr_o[0], min_o[0]}), 32'h0000);
        pulse(0, 0, 1, 0);
        pulses(0, 5, 1'b0, 1'b1);
        chk("set_hr05", 32'(hr_o[0]), 32'h05);
        blink_v[0] = 1;
        cyc(1);
        chk("blink_hi", 32'(blank_o[0]), 32'h4);
        blink_v[0] = 0;
        cyc(1);
        chk("blink_lo", 32'(blank_o[0]), 32'h0);
        pulses(0, 3, 1'b1, 1'b0);
        chk("sec_frozen", 32'(sec_o[0]), 32'h07);

        // mode+inc together: mode wins
        pulse(0, 0, 1, 1);
        chk("both_hr", 32'(hr_o[0]), 32'h05);
        chk("both_sm", 32'(sm_o[0]), 32'h1);
        blink_v[0] = 1;
        cyc(1);
        chk("blink_min", 32'(blank_o[0]), 32'h2);
        blink_v[0] = 0;

        // minute wrap in set mode, no carry
        pulses(0, 59, 1'b0, 1'b1);
        chk("set_min59", 32'(min_o[0]), 32'h59);
        pulse(0, 0, 0, 1);
        chk("min_wrap", 32'({hr_o[0], min_o[0]}), 32'h0500);
        pulse(0, 0, 1, 0);
        chk("leave_sec", 32'(sec_o[0]), 32'h00);
        chk("leave_sm", 32'(sm_o[0]), 32'h0);

        // asynchronous reset mid-set
        pulse(0, 0, 1, 0);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("async_hr", 32'(hr_o[0]), 32'h00);
        chk("async_sm", 32'(sm_o[0]), 32'h0);
        cyc(2);
        rst_n = 1;
        cyc(1);

        // 12 h: hour stepping then 12:59:59 wrap
        pulse(1, 0, 1, 0);
        pulses(1, 11, 1'b0, 1'b1);
        chk("h12_11", 32'(hr_o[1]), 32'h11);
        pulse(1, 0, 0, 1);
        chk("h12_12", 32'(hr_o[1]), 32'h12);
        pulse(1, 0, 1, 0);
        pulses(1, 59, 1'b0, 1'b1);
        pulse(1, 0, 1, 0);
        pulses(1, 59, 1'b1, 1'b0);
        chk("h12_pre", 32'({hr_o[1], min_o[1], sec_o[1]}), 32'h125959);
        pulse(1, 1, 0, 0);
        chk("h12_roll", 32'({hr_o[1], min_o[1], sec_o[1]}), 32'h010000);
        chk("h12_dt", 32'(dt_o[1]), 32'h1);
        cyc(1);
`ifdef ALARM_EN
        chk("alarm_on", 32'(al_o[1]), 32'h1);
        pulse(1, 0, 0, 1);
        chk("alarm_clr", 32'(al_o[1]), 32'h0);
        chk("alarm_min", 32'(min_o[1]), 32'h00);
        chk("alarm_sm", 32'(sm_o[1]), 32'h0);
`endif
        pulses(1, 4, 1'b1, 1'b0);
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
